conv_job_sender: RTL
====================

// Module: conv_job_sender
// PURPOSE
//  Transmit side of the convolution-engine stream protocol. On job_start, reads filter and image bytes from a
//  source SRAM and drives filter_valid/image_valid/in_data plus config sidebands to the conv engine.
//  It then collects the engine's out_valid/out_data burst into a result SRAM and reports done or error.
//  Sits between the host job-control registers and the conv engine.
// PARAMETERS
//  MAX_IMG    8    largest accepted image_size (N); N*N <= 64
//  ADDR_W     7    source SRAM address width
//  RES_AW     6    result SRAM address width
//  FILT_BASE  0    source address of filter[0][0], row-major
//  IMG_BASE   25   source address of image[0][0], row-major
//  TIMEOUT    64   max cycles without an out_valid beat in WAIT before error
// PORTS
//  clk              in   1       clock, rising edge
//  rst_n            in   1       asynchronous reset, active low
//  job_start        in   1       start pulse; sampled only in IDLE
//  job_filter_size  in   1       0 = 3x3 (K=3), 1 = 5x5 (K=5)
//  job_image_size   in   4       N, image is N x N
//  job_pad_mode     in   1       0 = zero, 1 = replication (forwarded only)
//  job_act_mode     in   1       0 = ReLU, 1 = leaky ReLU (forwarded only)
//  job_busy         out  1       high from the cycle after acceptance until done/err
//  job_done         out  1       1-cycle pulse, all N*N results written
//  job_err          out  1       1-cycle pulse, bad size or timeout
//  src_rd_en        out  1       source read strobe
//  src_rd_addr      out  ADDR_W  source read address
//  src_rd_data      in   8       signed; valid the cycle after src_rd_en
//  filter_valid     out  1       filter beat strobe to engine
//  image_valid      out  1       image beat strobe to engine
//  filter_size      out  1       = job_filter_size
//  image_size       out  4       = job_image_size
//  pad_mode         out  1       = job_pad_mode
//  act_mode         out  1       = job_act_mode
//  in_data          out  8       signed beat data
//  out_valid        in   1       engine result strobe
//  out_data         in   16      signed engine result
//  res_wr_en        out  1       result write strobe
//  res_wr_addr      out  RES_AW  result index 0..N*N-1
//  res_wr_data      out  16      result data
// BEHAVIOUR
//  Reset: every output 0, FSM IDLE, counters 0. Reset mid-job aborts at once; no done/err pulse.
//  FSM states and transitions:
//   IDLE -> FILT on job_start with 1 <= N <= MAX_IMG.
//   IDLE -> IDLE on job_start with N = 0 or N > MAX_IMG; job_err pulses next cycle, no reads.
//   FILT -> IMG after K*K reads. IMG -> WAIT after N*N reads.
//   WAIT -> IDLE with job_done after N*N beats. WAIT -> IDLE with job_err on timeout.
//  Timing, cycle 0 = cycle job_start is accepted:
//   - src_rd_en first high in cycle 1; reads are issued on consecutive cycles, no bubbles.
//   - Filter addresses are FILT_BASE..+K*K-1, then image addresses IMG_BASE..+N*N-1.
//   - in_data is src_rd_data registered, so each beat appears 2 cycles after its read; first filter_valid is cycle 3.
//   - filter_valid is high for exactly K*K contiguous cycles; image_valid follows in the very next cycle for N*N cycles.
//   - filter_valid and image_valid are never high together. in_data is 0 when neither is high.
//  Sidebands are latched at acceptance and held from the first filter_valid to the last image_valid; 0 otherwise.
//  WAIT is entered the cycle after the last image_valid.
//   - Each out_valid beat is registered to res_wr_* in the next cycle; address = beat count 0..N*N-1.
//   - job_done pulses the cycle after the last res_wr_en; job_busy drops in the same cycle.
//  Timeout: timer is cleared on WAIT entry and on every beat, and increments otherwise.
//   When timer = TIMEOUT-1 with no beat, job_err pulses next cycle, state goes IDLE, no job_done.
//  out_valid outside WAIT is ignored: no write, no error. job_start while busy is ignored.
//  A new job may be accepted in the cycle job_done/job_err is high.
//  Counters are 7 bits unsigned; K*K <= 25 and N*N <= 64, so there is no wrap.
// STRUCTURE
//  Shared package conv_pkg holds:
//   - enum state_e {IDLE, FILT, IMG, WAIT}
//   - constants FILT_BASE, IMG_BASE, MAX_IMG, K3 = 3, K5 = 5
//   - typedef pix_t (signed 8), res_t (signed 16)
//  Sub-module conv_rd_addr_gen: load(base, count) and step; drives addr/last; reused for filter and image phases.
// TESTING
//  1. K=3, N=4, pad=0, act=0: rd_addr 0..8 then 25..40; filter_valid cycles 3-11, image_valid 12-27; image_size=4 held.
//  2. K=5, N=8, pad=1, act=1; model returns 64 beats -> res_wr_addr 0..63 data match; done 1 cycle after last write.
//  3. job_image_size 0 then 9 -> job_err in cycle 1, src_rd_en/filter_valid/image_valid stay 0, busy stays 0.
//  4. job_start pulsed mid-IMG -> ignored, stream unchanged; new job_start in job_done cycle -> rd_en addr 0 next cycle.
//  5. No out_valid after last image_valid at cycle L -> job_err at L+65; 1-cycle gaps between beats do not time out.
//  6. rst_n low during image stream -> all outputs 0 same cycle; rerun of test 1 passes; stray out_valid in IDLE -> no res_wr_en.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution job sender.
//   state_e     : sender FSM states
//   pix_t/res_t : signed pixel/filter byte and signed engine result
//   filt_beats  : K*K for the selected filter size
//   img_beats   : N*N for a given image size
package conv_pkg;

  typedef enum logic [1:0] {StIdle, StFilt, StImg, StWait} state_e;

  localparam int unsigned FILT_BASE = 0;
  localparam int unsigned IMG_BASE  = 25;
  localparam int unsigned MAX_IMG   = 8;
  localparam int unsigned K3        = 3;
  localparam int unsigned K5        = 5;
  localparam int unsigned CNT_W     = 7;

  typedef logic signed [7:0]  pix_t;
  typedef logic signed [15:0] res_t;

  function automatic logic [CNT_W-1:0] filt_beats(input logic k5);
    return k5 ? CNT_W'(K5 * K5) : CNT_W'(K3 * K3);
  endfunction

  function automatic logic [CNT_W-1:0] img_beats(input logic [3:0] n);
    return CNT_W'(n) * CNT_W'(n);
  endfunction

endpackage

// File: rtl/conv_rd_addr_gen.sv
// Sequential read-address generator, reused for the filter and image phases.
//   load_i/base_i/count_i : start a run of count_i addresses at base_i (load wins over step)
//   step_i                : advance to the next address
//   addr_o                : current address
//   last_o                : current address is the final one of the run
module conv_rd_addr_gen #(
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned CNT_W  = 7
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [CNT_W-1:0]  count_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  remain_q;  // addresses left after the current one

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q   <= '0;
      remain_q <= '0;
    end else if (load_i) begin
      addr_q   <= base_i;
      remain_q <= count_i - CNT_W'(1);
    end else if (step_i) begin
      addr_q   <= addr_q + ADDR_W'(1);
      remain_q <= remain_q - CNT_W'(1);
    end
  end

  assign addr_o = addr_q;
  assign last_o = (remain_q == '0);

endmodule

// File: rtl/conv_job_sender.sv
// Transmit side of the conv-engine stream protocol.
// On an accepted job_start it reads K*K filter bytes then N*N image bytes from the source SRAM,
// streams them to the engine with filter_valid/image_valid and config sidebands, then collects
// N*N engine results into the result SRAM and reports done, or error on bad size / timeout.
//   job_*        : host job control and status
//   src_rd_*     : source SRAM read port (data valid the cycle after the strobe)
//   filter/image_valid, in_data, sidebands : stream to the engine
//   out_valid/out_data : result stream from the engine
//   res_wr_*     : result SRAM write port
module conv_job_sender #(
  parameter int unsigned MAX_IMG   = conv_pkg::MAX_IMG,
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned RES_AW    = 6,
  parameter int unsigned FILT_BASE = conv_pkg::FILT_BASE,
  parameter int unsigned IMG_BASE  = conv_pkg::IMG_BASE,
  parameter int unsigned TIMEOUT   = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     job_start_i,
  input  logic                     job_filter_size_i,
  input  logic [3:0]               job_image_size_i,
  input  logic                     job_pad_mode_i,
  input  logic                     job_act_mode_i,
  output logic                     job_busy_o,
  output logic                     job_done_o,
  output logic                     job_err_o,
  output logic                     src_rd_en_o,
  output logic [ADDR_W-1:0]        src_rd_addr_o,
  input  logic signed [7:0]        src_rd_data_i,
  output logic                     filter_valid_o,
  output logic                     image_valid_o,
  output logic                     filter_size_o,
  output logic [3:0]               image_size_o,
  output logic                     pad_mode_o,
  output logic                     act_mode_o,
  output logic signed [7:0]        in_data_o,
  input  logic                     out_valid_i,
  input  logic signed [15:0]       out_data_i,
  output logic                     res_wr_en_o,
  output logic [RES_AW-1:0]        res_wr_addr_o,
  output logic signed [15:0]       res_wr_data_o
);

  import conv_pkg::*;

  localparam int unsigned TmrW = $clog2(TIMEOUT) + 1;

  state_e            state_q;
  logic              k5_q, pad_q, act_q;
  logic [3:0]        n_q;
  logic              busy_q, done_q, err_q;
  logic              rd_en_q;
  // Read-tag pipeline: stage 1 lines up with src_rd_data, stage 2 with in_data.
  logic              s1_filt_q, s1_img_q, s1_last_q;
  logic              fv_q, iv_q, img_last_q;
  pix_t              in_data_q;
  logic              fs_q, pm_q, am_q;
  logic [3:0]        is_q;
  logic [CNT_W-1:0]  beat_cnt_q;
  logic [TmrW-1:0]   timer_q;
  logic              res_en_q;
  logic [RES_AW-1:0] res_addr_q;
  res_t              res_data_q;

  logic              size_ok, accept;
  logic              gen_load, gen_step, gen_last;
  logic [ADDR_W-1:0] gen_base, gen_addr;
  logic [CNT_W-1:0]  gen_count;

  assign size_ok = (job_image_size_i != 4'd0) && (32'(job_image_size_i) <= MAX_IMG);
  assign accept  = (state_q == StIdle) && job_start_i && size_ok;

  // The filter run chains straight into the image run so reads have no bubble.
  always_comb begin
    gen_load  = 1'b0;
    gen_step  = 1'b0;
    gen_base  = '0;
    gen_count = '0;
    if (accept) begin
      gen_load  = 1'b1;
      gen_base  = ADDR_W'(FILT_BASE);
      gen_count = filt_beats(job_filter_size_i);
    end else if (state_q == StFilt) begin
      if (gen_last) begin
        gen_load  = 1'b1;
        gen_base  = ADDR_W'(IMG_BASE);
        gen_count = img_beats(n_q);
      end else begin
        gen_step = 1'b1;
      end
    end else if ((state_q == StImg) && rd_en_q && !gen_last) begin
      gen_step = 1'b1;
    end
  end

  conv_rd_addr_gen #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_rd_addr_gen (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (gen_load),
    .base_i  (gen_base),
    .count_i (gen_count),
    .step_i  (gen_step),
    .addr_o  (gen_addr),
    .last_o  (gen_last)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      k5_q       <= 1'b0;
      n_q        <= '0;
      pad_q      <= 1'b0;
      act_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_en_q    <= 1'b0;
      s1_filt_q  <= 1'b0;
      s1_img_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      fv_q       <= 1'b0;
      iv_q       <= 1'b0;
      img_last_q <= 1'b0;
      in_data_q  <= '0;
      fs_q       <= 1'b0;
      is_q       <= '0;
      pm_q       <= 1'b0;
      am_q       <= 1'b0;
      beat_cnt_q <= '0;
      timer_q    <= '0;
      res_en_q   <= 1'b0;
      res_addr_q <= '0;
      res_data_q <= '0;
    end else begin
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      res_en_q   <= 1'b0;
      res_addr_q <= '0;
      res_data_q <= '0;

      // Stream pipeline: each read becomes a beat two cycles later.
      s1_filt_q  <= rd_en_q && (state_q == StFilt);
      s1_img_q   <= rd_en_q && (state_q == StImg);
      s1_last_q  <= gen_last;
      fv_q       <= s1_filt_q;
      iv_q       <= s1_img_q;
      img_last_q <= s1_img_q && s1_last_q;
      if (s1_filt_q || s1_img_q) begin
        in_data_q <= src_rd_data_i;
        fs_q      <= k5_q;
        is_q      <= n_q;
        pm_q      <= pad_q;
        am_q      <= act_q;
      end else begin
        in_data_q <= '0;
        fs_q      <= 1'b0;
        is_q      <= '0;
        pm_q      <= 1'b0;
        am_q      <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (job_start_i) begin
            if (size_ok) begin
              k5_q    <= job_filter_size_i;
              n_q     <= job_image_size_i;
              pad_q   <= job_pad_mode_i;
              act_q   <= job_act_mode_i;
              busy_q  <= 1'b1;
              rd_en_q <= 1'b1;
              state_q <= StFilt;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        StFilt: begin
          if (gen_last) state_q <= StImg;
        end
        StImg: begin
          if (rd_en_q && gen_last) rd_en_q <= 1'b0;
          // Leave once the final image beat has been presented to the engine.
          if (iv_q && img_last_q) begin
            state_q    <= StWait;
            beat_cnt_q <= '0;
            timer_q    <= '0;
          end
        end
        StWait: begin
          if (beat_cnt_q == img_beats(n_q)) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else if (out_valid_i) begin
            res_en_q   <= 1'b1;
            res_addr_q <= beat_cnt_q[RES_AW-1:0];
            res_data_q <= out_data_i;
            beat_cnt_q <= beat_cnt_q + CNT_W'(1);
            timer_q    <= '0;
          end else if (timer_q == TmrW'(TIMEOUT - 1)) begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end else begin
            timer_q <= timer_q + TmrW'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign job_busy_o     = busy_q;
  assign job_done_o     = done_q;
  assign job_err_o      = err_q;
  assign src_rd_en_o    = rd_en_q;
  assign src_rd_addr_o  = rd_en_q ? gen_addr : '0;
  assign filter_valid_o = fv_q;
  assign image_valid_o  = iv_q;
  assign filter_size_o  = fs_q;
  assign image_size_o   = is_q;
  assign pad_mode_o     = pm_q;
  assign act_mode_o     = am_q;
  assign in_data_o      = in_data_q;
  assign res_wr_en_o    = res_en_q;
  assign res_wr_addr_o  = res_addr_q;
  assign res_wr_data_o  = res_data_q;

endmodule
